// File: rtl/load_align_pkg.sv
// rtl/load_align_pkg.sv - shared load-mode constants, FSM states and size helper
package load_align_pkg;

  localparam logic [2:0] LB_F3  = 3'b000;
  localparam logic [2:0] LH_F3  = 3'b001;
  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] LD_F3  = 3'b011;
  localparam logic [2:0] LBU_F3 = 3'b100;
  localparam logic [2:0] LHU_F3 = 3'b101;
  localparam logic [2:0] LWU_F3 = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Access size in bytes; zero marks a mode with no defined size.
  function automatic logic [3:0] size_of(input logic [2:0] mode);
    case (mode)
      LB_F3, LBU_F3:  size_of = 4'd1;
      LH_F3, LHU_F3:  size_of = 4'd2;
      LW_F3, LWU_F3:  size_of = 4'd4;
      LD_F3:          size_of = 4'd8;
      default:        size_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects a byte/half/word/double from two beats and extends it
module load_extend
  import load_align_pkg::*;
#(
  parameter int D_WIDTH = 32,
  localparam int OFF_W = $clog2(D_WIDTH / 8)
) (
  input  logic [2*D_WIDTH-1:0] pair,
  input  logic [OFF_W-1:0]     off,
  input  logic [2:0]           mode,
  output logic [D_WIDTH-1:0]   result
);

  logic [2*D_WIDTH-1:0] shifted;
  logic [D_WIDTH-1:0]   keep_mask;
  logic [6:0]           nbits;
  logic                 sign_bit;

  // Shift the addressed byte to bit 0, mask to the access size, fill above with sign or zero.
  always_comb begin
    shifted   = pair >> {off, 3'b000};
    nbits     = {size_of(mode), 3'b000};
    keep_mask = '0;
    sign_bit  = 1'b0;
    for (int i = 0; i < D_WIDTH; i++) begin
      keep_mask[i] = (i < int'(nbits));
      if (i == int'(nbits) - 1) begin
        sign_bit = shifted[i] & ~mode[2];
      end
    end
    result = (shifted[D_WIDTH-1:0] & keep_mask) | ({D_WIDTH{sign_bit}} & ~keep_mask);
  end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - sequential load unit issuing one or two aligned RAM reads per load
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  localparam int OFF_W = $clog2(D_WIDTH / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [2:0]         req_mode,
  output logic               mem_re,
  output logic [A_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [D_WIDTH-1:0] resp_data,
  output logic               resp_err
);

  localparam int BYTES = D_WIDTH / 8;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   base_q;
  logic [OFF_W-1:0]     off_q;
  logic [2:0]           mode_q;
  logic                 split_q;
  logic                 err_q;
  logic                 fresh_q;
  logic [D_WIDTH-1:0]   beat0_q;
  logic [D_WIDTH-1:0]   hold_q;
  logic [D_WIDTH-1:0]   ext_result;
  logic [2*D_WIDTH-1:0] pair;
  logic                 legal;
  logic                 split;
  logic                 accept;
  logic [4:0]           end_byte;

  // Classify the incoming request: legality for this width and whether it crosses a word.
  always_comb begin
    legal = (req_mode != 3'b111);
    if (D_WIDTH == 32 && (req_mode == LD_F3 || req_mode == LWU_F3)) begin
      legal = 1'b0;
    end
    end_byte = 5'(req_addr[OFF_W-1:0]) + 5'(size_of(req_mode));
    split    = (end_byte > 5'(BYTES));
    accept   = req_valid && (state_q == IDLE);
  end

  // The final beat is consumed straight off mem_rdata in the first RESP cycle,
  // since the synchronous RAM only presents it then; earlier beats come from beat0_q.
  always_comb begin
    pair = '0;
    if (split_q) begin
      pair = {mem_rdata, beat0_q};
    end else begin
      pair = {{D_WIDTH{1'b0}}, mem_rdata};
    end
  end

  load_extend #(
    .D_WIDTH(D_WIDTH)
  ) u_extend (
    .pair  (pair),
    .off   (off_q),
    .mode  (mode_q),
    .result(ext_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake / RAM strobe outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = legal ? RD0 : RESP;
        end
      end
      RD0: begin
        mem_re   = 1'b1;
        mem_addr = base_q;
        state_d  = split_q ? RD1 : RESP;
      end
      RD1: begin
        mem_re   = 1'b1;
        mem_addr = base_q + A_WIDTH'(BYTES);
        state_d  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = fresh_q ? ext_result : hold_q;
        resp_err   = err_q;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, first-beat capture and result hold for a stalled response.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      off_q   <= '0;
      mode_q  <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      fresh_q <= 1'b0;
      beat0_q <= '0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        base_q  <= {req_addr[A_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        off_q   <= req_addr[OFF_W-1:0];
        mode_q  <= req_mode;
        split_q <= split && legal;
        err_q   <= !legal;
        fresh_q <= legal;
        hold_q  <= '0;
      end
      if (state_q == RD1) begin
        beat0_q <= mem_rdata;
      end
      if (state_q == RESP && fresh_q) begin
        hold_q  <= ext_result;
        fresh_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised, sequential successor to the combinational load-data extractor.
- Accepts one load request at a time and issues one or two word-aligned RAM reads.
- Handles loads that straddle a word boundary by merging two beats.
- Performs byte/half/word(/double) selection with sign or zero extension, then returns the result through a valid/ready response handshake.
- Sits between the execute stage and the synchronous data RAM.

Parameters:
- D_WIDTH, 32, data/RAM word width in bits; legal values 32 or 64.
- A_WIDTH, 32, byte-address width.
- OFF_W, $clog2(D_WIDTH/8), byte-offset width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  A_WIDTH  byte address.
- req_mode  in  3  RISC-V funct3 (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU).
- mem_re  out  1  RAM read strobe.
- mem_addr  out  A_WIDTH  word-aligned RAM address (low OFF_W bits zero).
- mem_rdata  in  D_WIDTH  RAM data, valid the cycle after mem_re.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  D_WIDTH  extended load result.
- resp_err  out  1  illegal mode for this D_WIDTH.

Behaviour:
- Reset: state IDLE; req_ready=1; mem_re=0; mem_addr=0; resp_valid=0; resp_data=0; resp_err=0.
- Access size in bytes: B=1, H=2, W=4, D=8.
  - LD and LWU are legal only when D_WIDTH=64.
  - Modes 111 (any width), and 011/110 when D_WIDTH=32, are illegal: no RAM read; go directly to RESP with resp_data=0 and resp_err=1.
- Let off = req_addr[OFF_W-1:0]. The access is split when off+size > D_WIDTH/8.
- States: IDLE, RD0, RD1, RESP.
- IDLE: on req_valid&&req_ready, latch addr, mode, off and split flag; go to RD0, or to RESP if the mode is illegal.
- RD0: mem_re=1, mem_addr = req_addr with low OFF_W bits cleared. Next cycle, capture mem_rdata as beat0.
  - Not split: go to RESP.
  - Split: go to RD1.
- RD1: mem_re=1, mem_addr = aligned address + D_WIDTH/8, wrapping modulo 2^A_WIDTH. Next cycle, capture mem_rdata as beat1 and go to RESP.
- Merge: form {beat1, beat0} (2*D_WIDTH bits), shift right by off*8, keep the low size*8 bits, then sign-extend (000/001/010/011) or zero-extend (100/101/110) to D_WIDTH. For non-split accesses beat1 is don't-care.
- RESP: resp_valid=1; resp_data and resp_err are stable until resp_ready. On resp_valid&&resp_ready, return to IDLE.
- req_ready=1 only in IDLE. No request is accepted in the cycle a response completes; the next acceptance is the following cycle.
- Latency from acceptance cycle T:
  - Aligned: resp_valid first asserted at T+2 (RD0 at T+1, capture at end of T+1).
  - Split: resp_valid at T+3.
  - Illegal: resp_valid at T+1.
- mem_re is high for exactly one cycle per beat, never in IDLE or RESP.
- Reset mid-operation: state returns to IDLE, captured beats are discarded, resp_valid drops the next cycle, and the mem_rdata that follows is ignored.
- A resp_ready held high continuously gives back-to-back throughput of one load per 3 cycles (aligned).

Decomposition:
- Package load_align_pkg holds:
  - funct3 constants (LB_F3 … LWU_F3);
  - state enum typedef (IDLE, RD0, RD1, RESP);
  - function size_of(mode) returning bytes.
- Sub-module load_extend (combinational, parametrised D_WIDTH): inputs {beat1, beat0}, off and mode; output is the extended result. It is the generalised replacement for the old byte/half selector.
- The FSM, beat registers and handshake stay in load_align_unit.

Test Plan:
- D=32, LB addr 0x103, RAM[0x100]=0x80AA5511 -> mem_addr 0x100; one mem_re pulse; resp_data 0xFFFFFF80 at T+2; resp_err 0.
- D=32, LHU addr 0x103, RAM[0x100]=0x12xxxxxx, RAM[0x104]=0xxxxxxx34 -> two reads (0x100, 0x104); resp_data 0x00003412 at T+3.
- D=32, LW addr 0x102, RAM[0x100]=0xBEEF0000, RAM[0x104]=0x0000DEAD -> resp_data 0xDEADBEEF; resp_ready held low 4 cycles -> resp_valid and resp_data stay stable; req_ready=0 throughout.
- D=64, LWU addr 0x6, RAM[0x0]=0x89AB_xxxx_xxxx_xxxx, RAM[0x8]=0xxxxx_xxxx_xxxx_CDEF -> resp_data 0x00000000CDEF89AB. Same access as LW -> resp_data 0xFFFFFFFFCDEF89AB.
- D=32, mode 011 -> no mem_re; resp_valid at T+1 with resp_data 0, resp_err 1.
- Split LW accepted, rst pulsed in RD1 -> next cycle IDLE, req_ready 1, resp_valid 0. Following aligned LW addr 0x200 returns RAM[0x200] correctly.
